// File: rtl/sram_array_ctl.sv
// Single-port SRAM array with per-way write masks, write-priority read/write channels,
// an optional post-reset zero-clear sweep and a registered read-data port.
module sram_array_ctl #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned WAYS         = 4,
  parameter int unsigned WAY_W        = 80,
  parameter bit          SHOULD_RESET = 1'b1,
  parameter bit          HOLD_READ    = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    r_valid,
  output logic                    r_ready,
  input  logic [ADDR_W-1:0]       r_addr,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [ADDR_W-1:0]       w_addr,
  input  logic [WAYS*WAY_W-1:0]   w_data,
  input  logic [WAYS-1:0]         w_mask,
  output logic                    r_resp_valid,
  output logic [WAYS*WAY_W-1:0]   r_data,
  output logic                    init_done
);

  localparam int unsigned SETS  = 1 << ADDR_W;
  localparam int unsigned ROW_W = WAYS * WAY_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ROW_W-1:0]  r_mem [SETS];
  logic [ROW_W-1:0]  r_rdata;
  logic              w_clr;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_clr_last;

  assign w_clr_last = (r_clr_cnt == {ADDR_W{1'b1}});
  assign w_rd_acc   = r_valid & r_ready;
  assign w_wr_acc   = w_valid & w_ready;
  assign r_data     = r_rdata;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= SHOULD_RESET ? ST_CLEAR : ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: CLEAR exits once the last set has been zeroed
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && w_clr_last) w_state_nxt = ST_IDLE;
  end

  // Outputs: writes win over reads; nothing is accepted while clearing
  always_comb begin
    w_clr     = 1'b0;
    w_ready   = 1'b0;
    r_ready   = 1'b0;
    init_done = 1'b0;
    case (r_state)
      ST_CLEAR: w_clr = 1'b1;
      ST_IDLE: begin
        w_ready   = 1'b1;
        r_ready   = !w_valid;
        init_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  r_clr_cnt <= '0;
    else if (w_clr && !w_clr_last) r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
  end

  // Array storage is deliberately outside reset; the clear sweep zeroes it
  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int i = 0; i < WAYS; i++) begin
        if (w_mask[i]) r_mem[w_addr][i*WAY_W +: WAY_W] <= w_data[i*WAY_W +: WAY_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_resp_valid <= w_rd_acc;
      if (w_rd_acc)        r_rdata <= r_mem[r_addr];
      else if (!HOLD_READ) r_rdata <= '0;
    end
  end

endmodule
